// File: rtl/x3q_burst_lsu_pkg.sv
// Shared x3q definitions: burst LSU state encoding and memory request-type codes.
package x3q_burst_lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } lsu_state_e;

   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

endpackage

// File: rtl/x3q_burst_lsu.sv
// Burst load/store master: walks len+1 strided beats, one outstanding request at a time,
// with per-beat response timeout and beat-boundary abort.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | cmd_ready high, waiting for a command
//   ST_ISSUE | read: one-cycle request; write: wr_ready high until wr_valid
//   ST_WAIT  | request outstanding, timing the response
//   ST_DONE  | one-cycle done pulse with err / beats_done, then back to idle
module x3q_burst_lsu
   import x3q_burst_lsu_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int MAX_BURST = 8,
   parameter int TIMEOUT   = 255,
   localparam int LEN_W    = $clog2(MAX_BURST)
)(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [ADDR_W-1:0] cmd_stride,
   input  logic              cmd_abort,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              err,
   output logic [LEN_W:0]    beats_done,
   output logic              request,
   output logic              request_type,
   output logic [ADDR_W-1:0] request_address,
   output logic [DATA_W-1:0] data_out,
   input  logic [DATA_W-1:0] memory_in,
   input  logic              memory_ready,
   input  logic              write_complete
);

   localparam int TMR_W = $clog2(TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);
   localparam logic [LEN_W:0]   CNT_ONE = (LEN_W+1)'(1);

   lsu_state_e        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr, r_stride;
   logic [LEN_W-1:0]  r_len;
   logic              r_write, r_abort, r_err;
   logic [LEN_W:0]    r_beats, r_beats_done;
   logic [TMR_W-1:0]  r_timer;
   logic [DATA_W-1:0] r_data_out, r_rd_data;
   logic              r_rd_valid;

   logic              w_abort_pend, w_resp, w_wr_fire, w_beat_ok, w_timeout, w_busy;
   logic [LEN_W:0]    w_beats_inc, w_last_cnt;

   assign w_abort_pend = r_abort | cmd_abort;
   assign w_resp       = r_write ? write_complete : memory_ready;
   assign w_busy       = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
   assign w_beats_inc  = r_beats + CNT_ONE;
   assign w_last_cnt   = {1'b0, r_len} + CNT_ONE;

   // A pending abort withdraws wr_ready so no write word is consumed on the way out.
   assign wr_ready  = (r_state == ST_ISSUE) && r_write && !w_abort_pend;
   assign w_wr_fire = wr_ready && wr_valid;

   always_comb begin
      w_state_nxt = r_state;
      w_beat_ok   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cmd_valid) w_state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (!r_write)          w_state_nxt = ST_WAIT;
            else if (w_abort_pend) w_state_nxt = ST_DONE;
            else if (wr_valid)     w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            // A response in the expiry cycle still completes the beat.
            if (w_resp) begin
               w_beat_ok = 1'b1;
               if ((w_beats_inc == w_last_cnt) || w_abort_pend) w_state_nxt = ST_DONE;
               else                                            w_state_nxt = ST_ISSUE;
            end else if (r_timer == TMR_MAX) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_addr       <= '0;
         r_stride     <= '0;
         r_len        <= '0;
         r_write      <= 1'b0;
         r_abort      <= 1'b0;
         r_err        <= 1'b0;
         r_beats      <= '0;
         r_beats_done <= '0;
         r_timer      <= '0;
         r_data_out   <= '0;
         r_rd_data    <= '0;
         r_rd_valid   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_rd_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_addr   <= cmd_addr;
                  r_stride <= cmd_stride;
                  r_len    <= cmd_len;
                  r_write  <= cmd_write;
                  r_abort  <= cmd_abort;
                  r_err    <= 1'b0;
                  r_beats  <= '0;
                  r_timer  <= '0;
               end
            end
            ST_ISSUE: begin
               r_abort <= w_abort_pend;
               if (w_wr_fire) r_data_out <= wr_data;
            end
            ST_WAIT: begin
               r_abort <= w_abort_pend;
               if (w_beat_ok) begin
                  r_beats <= w_beats_inc;
                  r_addr  <= r_addr + r_stride;
                  r_timer <= '0;
                  if (!r_write) begin
                     r_rd_valid <= 1'b1;
                     r_rd_data  <= memory_in;
                  end
               end else if (w_timeout) begin
                  r_err <= 1'b1;
               end else begin
                  r_timer <= r_timer + TMR_ONE;
               end
            end
            ST_DONE: begin
               r_abort      <= 1'b0;
               r_data_out   <= '0;
               r_beats_done <= r_beats;
            end
            default: ;
         endcase
      end
   end

   assign cmd_ready       = (r_state == ST_IDLE);
   assign request         = (r_state == ST_ISSUE) && (!r_write || w_wr_fire);
   assign request_type    = (w_busy && r_write) ? REQ_WRITE : REQ_READ;
   assign request_address = r_addr;
   assign data_out        = w_wr_fire ? wr_data : r_data_out;
   assign rd_valid        = r_rd_valid;
   assign rd_data         = r_rd_data;
   assign done            = (r_state == ST_DONE);
   assign err             = done && r_err;
   assign beats_done      = done ? r_beats : r_beats_done;

endmodule

// File: doc/x3q_burst_lsu.md
X3Q_BURST_LSU -- requirements
Module: x3q_burst_lsu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning memory word width.
REQ-002 The block SHALL have parameter ADDR_W, default 16, meaning memory address width.
REQ-003 The block SHALL have parameter MAX_BURST, default 8, meaning maximum beats per command (power of 2, ≥2); LEN_W = log2(MAX_BURST).
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning maximum wait cycles per beat before error (≥1).
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock (all state on rising edge); reset_n  in  1  async active-low reset.
REQ-006 The block SHALL have the following command ports: cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both high; cmd_write  in  1  0 read, 1 write; cmd_addr  in  ADDR_W  base address; cmd_len  in  LEN_W  beats minus one; cmd_stride  in  ADDR_W  address increment per beat; cmd_abort  in  1  stop at next beat boundary.
REQ-007 The block SHALL have the following data ports: wr_valid  in  1  write word available; wr_ready  out  1  write word consumed; wr_data  in  DATA_W  write word; rd_valid  out  1  read word pulse; rd_data  out  DATA_W  read word; done  out  1  one-cycle completion pulse; err  out  1  qualifies done, timeout occurred; beats_done  out  LEN_W+1  beats completed in last command.
REQ-008 The block SHALL have the following memory ports: request  out  1  one-cycle request pulse; request_type  out  1  0 read, 1 write; request_address  out  ADDR_W; data_out  out  DATA_W  write data; memory_in  in  DATA_W; memory_ready  in  1  read data valid; write_complete  in  1  write acknowledged.

Function
REQ-009 The FSM SHALL have the states IDLE, ISSUE, WAIT, DONE.
REQ-010 cmd_ready SHALL be high only in IDLE; on acceptance, addr, len, stride, write, beat count=0 and timer=0 SHALL be latched and the FSM SHALL go to ISSUE.
REQ-011 In ISSUE for a read, request=1, request_type=0 and request_address=current address SHALL be driven for exactly one cycle, followed by WAIT.
REQ-012 In ISSUE for a write, wr_ready=1; the block SHALL stay in ISSUE until wr_valid, and on that cycle SHALL capture wr_data into data_out and pulse request with request_type=1, followed by WAIT.
REQ-013 In WAIT, on memory_ready (read) or write_complete (write), rd_valid SHALL pulse with rd_data=memory_in (reads only), the beat count SHALL increment, the address SHALL advance by stride modulo 2^ADDR_W and the timer SHALL clear.
REQ-014 After a completed beat, the FSM SHALL go to DONE if the beat count equals len+1 or an abort is pending, and to ISSUE otherwise.
REQ-015 rd_valid SHALL have no backpressure, and the read latency SHALL be rd_valid in the cycle after memory_ready is sampled.
REQ-016 In WAIT without a response, the timer SHALL increment; on reaching TIMEOUT it SHALL set the error flag and go to DONE with no further beats.
REQ-017 If the response and the timeout expiry occur in the same cycle, the response SHALL win and no error is raised.
REQ-018 cmd_abort SHALL be sticky from acceptance until DONE; an abort in ISSUE while waiting for wr_valid SHALL go directly to DONE without a request.
REQ-019 DONE SHALL last one cycle, pulsing done, driving err and updating beats_done, then return to IDLE; request_type SHALL return to 0 and data_out to 0.
REQ-020 Responses received in IDLE, ISSUE or DONE SHALL be ignored.
REQ-021 At most one memory request SHALL be outstanding at any time.

Reset
REQ-022 With reset_n low, the FSM SHALL be in IDLE and all outputs SHALL be 0 except cmd_ready=1.
REQ-023 Reset asserted mid-burst SHALL abandon the burst immediately with no done pulse.

Structure
REQ-024 The FSM state encoding and the request_type READ/WRITE constants SHALL live in the shared x3q package.
REQ-025 The block SHALL be a single module with no sub-modules; it SHALL serve as the memory master for x3q16 load/store and Keccak lane transfers.

Verification
REQ-026 The bench SHALL cover a read burst: addr=0x0100, len=3, stride=1, memory_ready 2 cycles after each request -> addresses 0x0100..0x0103, 4 rd_valid, done with err=0, beats_done=4.
REQ-027 The bench SHALL cover a write burst: addr=0xFFFE, len=3, stride=1, wr_valid held off 3 cycles on beat 0 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, data_out matching wr_data, no request while wr_valid is low.
REQ-028 The bench SHALL cover a timeout: TIMEOUT=4, no response on beat 1 -> done with err=1, beats_done=1, no third request.
REQ-029 The bench SHALL cover an abort: cmd_abort pulsed during the WAIT of beat 0 of a len=7 read -> beat 0 completes, done with beats_done=1.
REQ-030 The bench SHALL cover simultaneous events: memory_ready on the cycle the timer reaches TIMEOUT -> beat accepted, err=0.
REQ-031 The bench SHALL cover reset mid-burst: reset_n low during beat 2 -> all outputs 0, cmd_ready=1, no done pulse, next command starts cleanly.
